// File: rtl/mu_bus_arbiter.sv
// mu_bus_arbiter: shares one MemoryUnit port between the CPU (master 0) and the DMA engine (master 1)
// Ports: clk, nreset (synchronous, active-low);
//        m0_*/m1_*: address/data/we/start requests in, busy/q handshake out, one private copy per master;
//        mu_*: single MemoryUnit bus (address/data/we/start out, initDone/busy/q in);
//        timeout_err: one-cycle pulse when the MemoryUnit never acknowledged a start.
module mu_bus_arbiter #(
  parameter int FIXED_PRIO  = 0,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [26:0] m0_address,
  input  logic [31:0] m0_data,
  input  logic        m0_we,
  input  logic        m0_start,
  output logic        m0_busy,
  output logic [31:0] m0_q,
  input  logic [26:0] m1_address,
  input  logic [31:0] m1_data,
  input  logic        m1_we,
  input  logic        m1_start,
  output logic        m1_busy,
  output logic [31:0] m1_q,
  output logic [26:0] mu_address,
  output logic [31:0] mu_data,
  output logic        mu_we,
  output logic        mu_start,
  input  logic        mu_initDone,
  input  logic        mu_busy,
  input  logic [31:0] mu_q,
  output logic        timeout_err
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, ACK = 2'd1, DONE = 2'd2;
  logic [1:0]        r_state;
  logic [1:0]        r_pend;
  logic [1:0][26:0]  r_addr;
  logic [1:0][31:0]  r_data;
  logic [1:0]        r_we;
  logic [1:0][31:0]  r_q;
  logic              r_last;
  logic              r_grant;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        w_start;
  logic [1:0][26:0]  w_addr;
  logic [1:0][31:0]  w_data;
  logic [1:0]        w_we;
  logic              w_grant;
  assign w_start = {m1_start, m0_start};
  assign w_addr  = {m1_address, m0_address};
  assign w_data  = {m1_data, m0_data};
  assign w_we    = {m1_we, m0_we};
  // a lone request wins outright; a contention goes to master 0 or to whoever did not win last time
  assign w_grant = (r_pend == 2'b11) ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last) : r_pend[1];
  assign m0_busy = r_pend[0];
  assign m1_busy = r_pend[1];
  assign m0_q    = r_q[0];
  assign m1_q    = r_q[1];
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_we        <= '0;
      r_q         <= '0;
      r_last      <= 1'b1;
      r_grant     <= 1'b0;
      r_cnt       <= '0;
      mu_address  <= '0;
      mu_data     <= '0;
      mu_we       <= 1'b0;
      mu_start    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mu_start    <= 1'b0;
      timeout_err <= 1'b0;
      // capture and completion never touch the same master: capture needs pend low, completion needs it high
      for (int i = 0; i < 2; i++)
        if (w_start[i] && !r_pend[i]) begin
          r_pend[i] <= 1'b1;
          r_addr[i] <= w_addr[i];
          r_data[i] <= w_data[i];
          r_we[i]   <= w_we[i];
        end
      case (r_state)
        IDLE:
          if (mu_initDone && |r_pend) begin
            r_grant    <= w_grant;
            r_last     <= w_grant;
            mu_address <= r_addr[w_grant];
            mu_data    <= r_data[w_grant];
            mu_we      <= r_we[w_grant];
            mu_start   <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ACK;
          end
        ACK:
          if (mu_busy) r_state <= DONE;
          else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
            timeout_err     <= 1'b1;
            r_q[r_grant]    <= '0;
            r_pend[r_grant] <= 1'b0;
            r_state         <= IDLE;
          end else r_cnt <= r_cnt + 1'b1;
        DONE:
          if (!mu_busy) begin
            r_q[r_grant]    <= mu_q;
            r_pend[r_grant] <= 1'b0;
            r_state         <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mu_bus_arbiter.sv
// tb_mu_bus_arbiter: checks a round-robin and a fixed-priority arbiter against a transaction-level model
module tb_mu_bus_arbiter;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;
  logic [26:0] m0_address, m1_address;
  logic [31:0] m0_data, m1_data;
  logic m0_we, m1_we, m0_start, m1_start, mu_initDone;
  logic [1:0] m0_busy, m1_busy, mu_we, mu_start, timeout_err, mu_busy;
  logic [1:0][31:0] m0_q, m1_q, mu_data, mu_q;
  logic [1:0][26:0] mu_address;
  for (genvar d = 0; d < 2; d++) begin : g_dut
    mu_bus_arbiter #(.FIXED_PRIO(d), .ACK_TIMEOUT(TO)) u_dut (
      .clk(clk), .nreset(nreset),
      .m0_address(m0_address), .m0_data(m0_data), .m0_we(m0_we), .m0_start(m0_start),
      .m0_busy(m0_busy[d]), .m0_q(m0_q[d]),
      .m1_address(m1_address), .m1_data(m1_data), .m1_we(m1_we), .m1_start(m1_start),
      .m1_busy(m1_busy[d]), .m1_q(m1_q[d]),
      .mu_address(mu_address[d]), .mu_data(mu_data[d]), .mu_we(mu_we[d]), .mu_start(mu_start[d]),
      .mu_initDone(mu_initDone), .mu_busy(mu_busy[d]), .mu_q(mu_q[d]), .timeout_err(timeout_err[d]));
  end
  logic [1:0]  e_pend [2];
  logic [26:0] e_ha [2][2];
  logic [31:0] e_hd [2][2];
  logic        e_hw [2][2];
  logic [31:0] e_q [2][2];
  logic [31:0] e_cq [2];
  logic [26:0] e_ma [2];
  logic [31:0] e_md [2];
  logic        e_mw [2], e_ms [2], e_te [2], e_last [2], e_act [2], e_tmo [2];
  int e_g [2], e_done [2], e_plan [2], mem_left [2], gn [2];
  int gseq [2][64];
  int cyc = 0, tests = 0, fails = 0, force_d = -1;
  logic use_fq = 1'b0;
  logic [31:0] force_q = '0;
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask
  task automatic model_step(input int i);
    logic [1:0] p, st;
    int g, dl;
    p = e_pend[i];
    st = {m1_start, m0_start};
    e_ms[i] = 1'b0;
    e_te[i] = 1'b0;
    if (!nreset) begin
      e_pend[i] = '0; e_q[i][0] = '0; e_q[i][1] = '0; e_last[i] = 1'b1; e_act[i] = 1'b0;
      e_ma[i] = '0; e_md[i] = '0; e_mw[i] = 1'b0; gn[i] = 0;
    end else begin
      if (e_act[i] && cyc == e_done[i]) begin
        e_q[i][e_g[i]] = e_tmo[i] ? 32'h0 : e_cq[i];
        e_pend[i][e_g[i]] = 1'b0;
        e_te[i] = e_tmo[i];
        e_act[i] = 1'b0;
      end else if (!e_act[i] && mu_initDone && p != 2'b00) begin
        g = (p == 2'b11) ? ((i == 1) ? 0 : (e_last[i] ? 0 : 1)) : (p[1] ? 1 : 0);
        e_g[i] = g; e_last[i] = (g == 1); e_act[i] = 1'b1; e_ms[i] = 1'b1;
        e_ma[i] = e_ha[i][g]; e_md[i] = e_hd[i][g]; e_mw[i] = e_hw[i][g];
        dl = (force_d >= 0) ? force_d : (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)));
        e_plan[i] = dl;
        e_cq[i] = use_fq ? force_q : $urandom;
        e_tmo[i] = (dl == 0);
        e_done[i] = (dl == 0) ? cyc + TO : cyc + dl + 1;
        if (gn[i] < 64) gseq[i][gn[i]] = g;
        gn[i]++;
      end
      for (int m = 0; m < 2; m++)
        if (st[m] && !p[m]) begin
          e_pend[i][m] = 1'b1;
          e_ha[i][m] = m ? m1_address : m0_address;
          e_hd[i][m] = m ? m1_data : m0_data;
          e_hw[i][m] = m ? m1_we : m0_we;
        end
    end
  endtask
  task automatic compare(input int i);
    chk("m0_busy", i, 32'(m0_busy[i]), 32'(e_pend[i][0]));
    chk("m1_busy", i, 32'(m1_busy[i]), 32'(e_pend[i][1]));
    chk("m0_q", i, m0_q[i], e_q[i][0]);
    chk("m1_q", i, m1_q[i], e_q[i][1]);
    chk("mu_start", i, 32'(mu_start[i]), 32'(e_ms[i]));
    chk("mu_address", i, 32'(mu_address[i]), 32'(e_ma[i]));
    chk("mu_data", i, mu_data[i], e_md[i]);
    chk("mu_we", i, 32'(mu_we[i]), 32'(e_mw[i]));
    chk("timeout_err", i, 32'(timeout_err[i]), 32'(e_te[i]));
  endtask
  task automatic mem_step(input int i);
    if (!nreset) begin
      mu_busy[i] = 1'b0;
      mem_left[i] = 0;
    end else if (mu_start[i]) begin
      mem_left[i] = e_plan[i];
      mu_busy[i] = (e_plan[i] > 0);
      mu_q[i] = e_cq[i];
    end else if (mem_left[i] > 0) begin
      mem_left[i]--;
      mu_busy[i] = (mem_left[i] > 0);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) compare(i);
    for (int i = 0; i < 2; i++) mem_step(i);
    m0_start = 1'b0;
    m1_start = 1'b0;
  endtask
  function automatic logic busy_model();
    return e_act[0] || e_act[1] || e_pend[0] != 2'b00 || e_pend[1] != 2'b00;
  endfunction
  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy_model() && n < lim) begin
      tick;
      n++;
    end
    if (n >= lim) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", lim);
    end
  endtask
  task automatic do_reset;
    nreset = 1'b0;
    tick;
    nreset = 1'b1;
    tick;
  endtask
  task automatic req(input int m, input logic [26:0] a, input logic [31:0] dt, input logic w);
    if (m == 0) begin m0_address = a; m0_data = dt; m0_we = w; m0_start = 1'b1; end
    else begin m1_address = a; m1_data = dt; m1_we = w; m1_start = 1'b1; end
  endtask
  initial begin
    int cnt [2];
    m0_address = '0; m1_address = '0; m0_data = '0; m1_data = '0; m0_we = 0; m1_we = 0;
    m0_start = 0; m1_start = 0; mu_initDone = 1'b1; mu_busy = '0; mu_q = '0;
    for (int i = 0; i < 2; i++) begin
      e_pend[i] = '0; e_act[i] = 0; e_plan[i] = 0; mem_left[i] = 0; gn[i] = 0; e_last[i] = 1;
    end
    nreset = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 2; i++) begin
      chk("rst_m0_busy", i, 32'(m0_busy[i]), 0);
      chk("rst_mu_start", i, 32'(mu_start[i]), 0);
      chk("rst_m1_q", i, m1_q[i], 0);
    end
    nreset = 1'b1;
    tick;
    mu_initDone = 1'b0; force_d = 4; use_fq = 1'b1; force_q = 32'hDEADBEEF;
    req(0, 27'h0000123, 32'h0, 1'b0);
    tick;
    for (int k = 0; k < 5; k++) begin
      tick;
      for (int i = 0; i < 2; i++) chk("init_hold_start", i, 32'(mu_start[i]), 0);
    end
    for (int i = 0; i < 2; i++) chk("init_hold_busy", i, 32'(m0_busy[i]), 1);
    mu_initDone = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) chk("first_addr", i, 32'(mu_address[i]), 32'h123);
    wait_idle(40);
    for (int i = 0; i < 2; i++) chk("first_q", i, m0_q[i], 32'hDEADBEEF);
    do_reset;
    force_d = -1; use_fq = 1'b0;
    for (int k = 0; k < 80; k++) begin
      req(0, 27'h0000AAA, 32'h0, 1'b0);
      req(1, 27'h0000BBB, 32'h0, 1'b0);
      tick;
    end
    wait_idle(60);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++) chk("alternate", i, 32'(gseq[i][k]), 32'(k % 2));
    do_reset;
    force_d = 2;
    req(0, 27'h10, 32'h0, 1'b0);
    tick;
    wait_idle(20);
    req(0, 27'h20, 32'h0, 1'b0);
    req(1, 27'h21, 32'h0, 1'b0);
    tick;
    wait_idle(40);
    chk("rr_contend", 0, 32'(gseq[0][1]), 1);
    chk("fp_contend", 1, 32'(gseq[1][1]), 0);
    chk("fp_then_m1", 1, 32'(gseq[1][2]), 1);
    force_d = 0;
    cnt = '{0, 0};
    req(1, 27'h300, 32'h0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      tick;
      for (int i = 0; i < 2; i++) cnt[i] += int'(timeout_err[i]);
    end
    for (int i = 0; i < 2; i++) begin
      chk("timeout_pulses", i, 32'(cnt[i]), 1);
      chk("timeout_q", i, m1_q[i], 0);
      chk("timeout_busy", i, 32'(m1_busy[i]), 0);
    end
    force_d = 3; use_fq = 1'b1; force_q = 32'h11111111;
    req(0, 27'h400, 32'h0, 1'b0);
    tick;
    wait_idle(20);
    for (int i = 0; i < 2; i++) chk("after_timeout_q", i, m0_q[i], 32'h11111111);
    force_d = 2; force_q = 32'h0;
    req(1, 27'h500, 32'hA5A5A5A5, 1'b1);
    tick;
    tick;
    for (int i = 0; i < 2; i++) begin
      chk("wr_we", i, 32'(mu_we[i]), 1);
      chk("wr_data", i, mu_data[i], 32'hA5A5A5A5);
    end
    wait_idle(20);
    for (int i = 0; i < 2; i++) chk("wr_m0_q_kept", i, m0_q[i], 32'h11111111);
    force_d = 10;
    req(0, 27'h600, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++) tick;
    nreset = 1'b0;
    tick;
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_busy", i, 32'(m0_busy[i]), 0);
      chk("mid_rst_q", i, m0_q[i], 0);
      chk("mid_rst_addr", i, 32'(mu_address[i]), 0);
    end
    nreset = 1'b1;
    tick;
    force_d = 2; force_q = 32'h0BADF00D;
    cnt = '{0, 0};
    for (int k = 0; k < 5; k++) begin
      req(0, 27'h700, 32'h0, 1'b0);
      tick;
      for (int i = 0; i < 2; i++) cnt[i] += int'(mu_start[i]);
    end
    wait_idle(20);
    for (int i = 0; i < 2; i++) begin
      chk("one_start", i, 32'(cnt[i]), 1);
      chk("post_rst_q", i, m0_q[i], 32'h0BADF00D);
    end
    force_d = -1; use_fq = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) req(0, 27'($urandom), $urandom, 1'($urandom));
      if ($urandom_range(0, 2) == 0) req(1, 27'($urandom), $urandom, 1'($urandom));
      mu_initDone = ($urandom_range(0, 9) != 0);
      nreset = ($urandom_range(0, 199) != 0);
      tick;
    end
    nreset = 1'b1;
    mu_initDone = 1'b1;
    wait_idle(100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mu_bus_arbiter.md
Name: mu_bus_arbiter

Overview:
Two-master arbiter that shares the MemoryUnit CPU bus (address/data/we/start/busy/q) between the CPU (master 0) and a DMA/blitter engine (master 1). Each master sees a private copy of the start/busy/q handshake. The arbiter serialises their transactions onto the single MemoryUnit port. It sits between the CPU/DMA and the MemoryUnit in the FPGC5 top level.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins a contention.
- ACK_TIMEOUT, 15, maximum cycles to wait for mu_busy to rise after mu_start before aborting (4-bit counter is sufficient for the default).

Ports:
- clk  in  1  system clock.
- nreset  in  1  synchronous, active-low reset.
- m0_address  in  27  master 0 (CPU) address.
- m0_data  in  32  master 0 write data.
- m0_we  in  1  master 0 write enable.
- m0_start  in  1  master 0 one-cycle request pulse.
- m0_busy  out  1  master 0 request pending or in service.
- m0_q  out  32  master 0 read data.
- m1_address, m1_data, m1_we, m1_start, m1_busy, m1_q  same as m0_*, for master 1 (DMA).
- mu_address  out  27  to MemoryUnit.
- mu_data  out  32  to MemoryUnit.
- mu_we  out  1  to MemoryUnit.
- mu_start  out  1  to MemoryUnit.
- mu_initDone  in  1  MemoryUnit initialisation complete.
- mu_busy  in  1  from MemoryUnit.
- mu_q  in  32  from MemoryUnit.
- timeout_err  out  1  one-cycle pulse on an aborted transaction.

Behaviour:
- Reset (nreset=0 at a clk edge): all outputs are 0, the state is IDLE, both pending flags are cleared, last_grant=1 so master 0 wins the first contention, and the timeout counter is 0.
- Reset mid-transaction: the transaction is abandoned with no completion. The MemoryUnit is reset by the same system reset.
- Capture: mX_start=1 while mX_busy=0 sets pendX and latches mX_address/data/we into a holding register on that edge.
  - mX_start while mX_busy=1 is ignored.
- mX_busy = pendX, registered. It rises the cycle after the start pulse.
- FSM states: IDLE, ACK, DONE.
- IDLE:
  - The FSM waits while mu_initDone=0. Pending requests are held.
  - Otherwise, if any pend is set, select grant. With one pending, grant it. With both pending: if FIXED_PRIO=1 grant 0; otherwise grant ~last_grant.
  - On the same edge: load mu_address/data/we from grant's holding register, set mu_start=1, set last_grant=grant, clear the counter, go to ACK.
  - A request captured on the same edge is only eligible from the next cycle.
- ACK:
  - mu_start=0 from the first ACK cycle, so mu_start is exactly one cycle wide.
  - If mu_busy=1, go to DONE.
  - Else increment the counter. When the counter reaches ACK_TIMEOUT: pulse timeout_err, load mGrant_q=0, clear pendGrant, go to IDLE.
- DONE:
  - Hold mu_address/data/we.
  - When mu_busy=0: latch mu_q into mGrant_q, clear pendGrant, go to IDLE.
  - mGrant_busy falls on this same edge, so q is valid the first cycle busy is low.
- mX_q holds its value until that master's next completion. It is updated for reads and writes alike.
- Back-to-back: a master may pulse start the cycle its busy falls.
  - Minimum master latency from start pulse to busy low = 3 cycles + MemoryUnit busy duration.
  - A new grant is issued the cycle after DONE→IDLE.
- Simultaneous starts from both masters on one edge: both are captured. Arbitration then follows the priority rule.
- Starvation: in round-robin mode, with both masters requesting continuously, grants strictly alternate 0,1,0,1.
- The outputs of the non-granted master are never modified during the other's transaction.

Test Plan:
- Hold mu_initDone=0, pulse m0_start (addr=0x0000123, we=0) → m0_busy=1, mu_start stays 0. Raise initDone → one-cycle mu_start with mu_address=0x0000123. Model asserts mu_busy 4 cycles then returns mu_q=0xDEADBEEF → m0_q=0xDEADBEEF on the cycle m0_busy falls.
- m0 and m1 pulse start on the same edge, FIXED_PRIO=0, after reset → grant order 0 then 1. Repeat 4 rounds with continuous requests → mu_address alternates between m0 and m1 addresses.
- FIXED_PRIO=1, m1 pending, m0 re-requests every completion → m0 is always granted and m1 waits. Stop m0 → m1 is granted next.
- Model never raises mu_busy → after 15 ACK cycles timeout_err pulses once, m1_q=0, m1_busy falls, FSM returns to IDLE and serves the next request normally.
- Write m1 (we=1, data=0xA5A5A5A5) while m0_q=0x11111111 → mu_we=1 and mu_data=0xA5A5A5A5 during the transaction; m0_q is unchanged.
- Assert nreset=0 during DONE, then release → all outputs 0, pending cleared, next m0 request completes normally; extra m0_start pulses while m0_busy=1 produce no extra mu_start.
